// File: rtl/store_align_unit.sv
// ---------------------------------------------------------------------------
// store_align_unit
//
// Performs byte, halfword and word stores into a 32-bit word-addressed RAM
// with a one-cycle synchronous read. Sub-word stores do read-modify-write:
// the old word is read, the new bytes are merged into the addressed lanes,
// and the merged word is written back. Word stores skip the read.
//
// Byte lanes are little-endian: data byte i of the store goes to lane
// (addr[1:0] + i) mod 4. This is equivalent to rotating the old word right
// by 8*addr[1:0], overwriting the low bytes, and rotating back left. A
// halfword at offset 3 therefore wraps into lanes [31:24] and [7:0] of the
// same word, and a word store at a non-zero offset is written rotated.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req          store request, sampled only while idle
//   addr         byte address; bits [ADDR_W+1:2] select the RAM word
//   wdata        store data, right-justified for byte and halfword
//   size         00 byte, 01 halfword, 10 word, 11 treated as word
//   ram_q        RAM read data, valid one cycle after the address
//   ram_address  RAM word address
//   ram_data     RAM write data
//   ram_wren     RAM write enable, high only in the write cycle
//   busy         high while a store is in flight
//   done         one-cycle pulse in the write cycle of each store
// ---------------------------------------------------------------------------
module store_align_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    input  logic [31:0]       ram_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;

    // Address bits above the RAM word address are deliberately ignored.
    logic addr_unused;
    assign addr_unused = ^addr[31:ADDR_W+2];

    // Rotate left by 8*r bits.
    function automatic logic [31:0] rotl8(input logic [31:0] x, input logic [1:0] r);
        logic [31:0] y;
        case (r)
            2'd0:    y = x;
            2'd1:    y = {x[23:0], x[31:24]};
            2'd2:    y = {x[15:0], x[31:16]};
            default: y = {x[7:0],  x[31:8]};
        endcase
        return y;
    endfunction

    // Rotate right by 8*r bits.
    function automatic logic [31:0] rotr8(input logic [31:0] x, input logic [1:0] r);
        logic [31:0] y;
        case (r)
            2'd0:    y = x;
            2'd1:    y = {x[7:0],  x[31:8]};
            2'd2:    y = {x[15:0], x[31:16]};
            default: y = {x[23:0], x[31:24]};
        endcase
        return y;
    endfunction

    // Bring the addressed lane down to bit 0, overwrite the store bytes
    // there, then rotate back so the bytes land in their lanes (with
    // wrap-around inside the word for a halfword at offset 3).
    function automatic logic [31:0] merge_word(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  r);
        logic [31:0] v;
        v = rotr8(old, r);
        case (sz)
            2'b00:   v[7:0]  = data[7:0];
            2'b01:   v[15:0] = data[15:0];
            default: v       = data;
        endcase
        return rotl8(v, r);
    endfunction

    // Control and the RAM-facing registers share the asynchronous reset so
    // that ram_wren, ram_address and ram_data all clear the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lane        <= 2'd0;
            size_q      <= 2'b00;
            wdata_q     <= 32'd0;
            ram_address <= '0;
            ram_data    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lane        <= addr[1:0];
                        size_q      <= size;
                        wdata_q     <= wdata;
                        ram_address <= addr[ADDR_W+1:2];
                        // A word store is complete as soon as it is rotated;
                        // sub-word stores overwrite this after the merge.
                        ram_data    <= rotl8(wdata, addr[1:0]);
                        if (size[1]) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state <= MERGE;
                end
                MERGE: begin
                    // ram_q now holds the old word addressed during READ.
                    ram_data <= merge_word(ram_q, wdata_q, size_q, lane);
                    state    <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pure state decodes: no path from req, and an asynchronous reset of the
    // state register drops them immediately.
    assign busy     = (state != IDLE);
    assign done     = (state == WRITE);
    assign ram_wren = (state == WRITE);

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;

    store_align_unit #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .addr        (addr),
        .wdata       (wdata),
        .size        (size),
        .ram_q       (ram_q),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Bench RAM: 16 words, aliased on the low word-address bits, one-cycle read.
    logic [31:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    always @(posedge clk) begin
        ram_q <= mem[ram_address[3:0]];
        if (pre_en)        mem[pre_idx] <= pre_val;
        else if (ram_wren) mem[ram_address[3:0]] <= ram_data;
    end

    // Reference model: byte-addressed memory plus a count of busy cycles left.
    logic [7:0]        ref_mem [16][4];
    int                rem = 0;
    int                p_w = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_data = 32'd0;
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[w][3], ref_mem[w][2], ref_mem[w][1], ref_mem[w][0]};
    endfunction

    // Called at each falling edge: check this cycle, then predict the next.
    task automatic step();
        logic [7:0] b [4];
        int         nb;
        int         ln;
        int         w;
        if (pre_en) begin
            for (int k = 0; k < 4; k++) ref_mem[pre_idx][k] = pre_val[8*k +: 8];
        end
        if (rst) begin
            rem = 0;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_wren", {31'd0, ram_wren}, 32'd0);
            chk("rst_addr", {16'd0, ram_address}, 32'd0);
            chk("rst_data", ram_data, 32'd0);
        end else begin
            chk("busy", {31'd0, busy}, (rem > 0) ? 32'd1 : 32'd0);
            chk("done", {31'd0, done}, (rem == 1) ? 32'd1 : 32'd0);
            chk("wren", {31'd0, ram_wren}, (rem == 1) ? 32'd1 : 32'd0);
            if (rem > 0) chk("addr", {16'd0, ram_address}, {16'd0, exp_addr});
            if (rem == 1) begin
                chk("data", ram_data, exp_data);
                for (int k = 0; k < 4; k++) ref_mem[p_w][k] = exp_data[8*k +: 8];
            end
            if (rem > 0) begin
                rem--;
            end else if (req) begin
                w  = int'(addr[5:2]);
                ln = int'(addr[1:0]);
                nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
                for (int k = 0; k < 4; k++) b[k] = ref_mem[w][k];
                for (int i = 0; i < nb; i++) b[(ln + i) % 4] = wdata[8*i +: 8];
                exp_data = {b[3], b[2], b[1], b[0]};
                exp_addr = addr[ADDR_W+1:2];
                p_w      = w;
                rem      = (nb == 4) ? 1 : 3;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        cyc();
        pre_en  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req = 1'b1; addr = a; wdata = d; size = s;
        cyc();
        req = 1'b0;
    endtask

    // Cycles from the accept edge until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 8) begin
            cyc();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        logic [31:0] w4;
        req = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        rst = 1'b0;
        cyc();

        // Aligned word store: written next cycle, no read.
        issue(32'h0000_0010, 32'hAABBCCDD, 2'b10);
        chk("w_addr", {16'd0, ram_address}, 32'd4);
        chk("w_data", ram_data, 32'hAABBCCDD);
        chk("w_wren", {31'd0, ram_wren}, 32'd1);
        chk("w_done", {31'd0, done}, 32'd1);
        cyc();

        // Misaligned word store is written rotated.
        issue(32'h0000_0011, 32'h11223344, 2'b10);
        chk("wr_data", ram_data, 32'h22334411);
        cyc();
        w4 = mem[4];
        chk("wr_rotload", (w4 >> 8) | (w4 << 24), 32'h11223344);

        // Byte store read-modify-write.
        preload(2, 32'h01020304);
        issue(32'h0000_000A, 32'h0000_00FF, 2'b00);
        chk("b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("b_lat", lat, 32'd3);
        chk("b_data", ram_data, 32'h01FF0304);
        chk("b_addr", {16'd0, ram_address}, 32'd2);
        cyc();

        // Halfword at offset 3 wraps inside the word; upper wdata ignored.
        preload(0, 32'h01020304);
        issue(32'h0000_0003, 32'h1234BEEF, 2'b01);
        wait_done(lat);
        chk("h_data", ram_data, 32'hEF0203BE);
        cyc();

        // req held through a byte store: exactly one done, other requests dropped.
        req = 1'b1; addr = 32'h0000_001C; wdata = 32'h0000_0055; size = 2'b00;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            addr = 32'h0000_0020 + 32'(i); wdata = $urandom;
            if (done) cnt++;
        end
        req = 1'b0;
        chk("held_dones", cnt, 32'd1);
        cyc(); cyc(); cyc(); cyc();

        // Back-to-back word stores with req held high.
        req = 1'b1; size = 2'b10;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            addr = 32'h0000_0024 + 32'(4 * i); wdata = $urandom;
            cyc();
            if (done) cnt++;
        end
        req = 1'b0;
        chk("bb_dones", cnt, 32'd3);
        cyc();

        // Reset during MERGE abandons the store.
        preload(5, 32'hCAFEF00D);
        issue(32'h0000_0015, 32'h0000_0077, 2'b00);
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_wren", {31'd0, ram_wren}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        cyc();
        rst = 1'b0;
        // First edge after reset with req accepts.
        issue(32'h0000_0018, 32'h5A5A1234, 2'b10);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        cyc();
        chk("ab_mem", mem[5], 32'hCAFEF00D);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 600; n++) begin
            req   = ($urandom_range(0, 9) < 7);
            addr  = $urandom;
            wdata = $urandom;
            size  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                #1 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end
        req = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], ref_word(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
